store_buffer_fifo: RTL and testbench
====================================

Name: store_buffer_fifo

Overview:
Parametrised multi-entry store buffer between the CPU data port and the dcache. It generalises the single-entry buffer:
- CPU stores retire in one cycle into a DEPTH-entry FIFO.
- The FIFO drains in order to the dcache, one transaction at a time.
- Loads bypass the buffer when there is no address hazard.
- Full-word store-to-load forwarding is available (FWD_EN).
- A load that hits a buffered store it cannot forward from stalls until that store has drained.

Parameters:
DEPTH, 4, number of buffered stores (power of two, 2..16)
FWD_EN, 1, 1 = forward a load from the youngest matching full-word store; 0 = every matching load stalls
CNT_W, $clog2(DEPTH)+1, width of sb_count

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
cpu_data_req  in  1  CPU request valid
cpu_data_wr  in  1  1 = store, 0 = load
cpu_data_size  in  2  access size, passed through
cpu_data_addr  in  32  byte address
cpu_data_wdata  in  32  store data
cpu_data_wstrb  in  4  store byte enables
cpu_data_rdata  out  32  load data, valid with cpu_data_data_ok
cpu_data_addr_ok  out  1  request accepted this cycle
cpu_data_data_ok  out  1  response for the oldest accepted request
dcache_data_req  out  1  dcache request valid
dcache_data_wr  out  1  dcache write
dcache_data_size  out  2  dcache size
dcache_data_addr  out  32  dcache address
dcache_data_wdata  out  32  dcache write data
dcache_data_wstrb  out  4  dcache byte enables
dcache_data_rdata  in  32  dcache read data
dcache_data_addr_ok  in  1  dcache accepted request
dcache_data_data_ok  in  1  dcache response
sb_empty  out  1  FIFO holds no entries
sb_count  out  CNT_W  number of occupied entries

Behaviour:
- Reset: asynchronous, active-low.
  - Clears all valid bits and head/tail pointers; state returns to IDLE.
  - Clears the registered cpu_data_data_ok and cpu_data_rdata to 0.
  - While resetn=0, all outputs are 0 except sb_empty=1.
  - Reset in mid-transaction abandons the transaction; no response is generated afterwards.
- Entry fields: {addr[31:0], size, wdata, wstrb}. Hazard match compares addr[31:2] only.
- Dcache state machine, at most one outstanding dcache transaction:
  - IDLE: a load is issued if the load path below allows it; otherwise, if the FIFO is not empty, the head entry is driven with dcache_data_wr=1. On dcache_data_addr_ok, go to WAIT_ST (store) or WAIT_LD (load).
  - WAIT_ST: dcache_data_req=0. On dcache_data_data_ok: pop head, return to IDLE.
  - WAIT_LD: dcache_data_req=0. On dcache_data_data_ok: drive cpu_data_rdata=dcache_data_rdata and pulse cpu_data_data_ok the same cycle, return to IDLE.
- Store path:
  - cpu_data_addr_ok=1 combinationally when cpu_data_req&cpu_data_wr, sb_count<DEPTH and state!=WAIT_LD.
  - The entry is pushed at the tail on that edge. cpu_data_data_ok pulses exactly 1 cycle later (registered); rdata is don't-care.
  - Full (sb_count==DEPTH) blocks acceptance even if a pop happens the same cycle.
  - A push and a pop in the same cycle leave sb_count unchanged.
- Load path: evaluate word-address match against all valid entries, including the entry currently draining.
  - No match, state IDLE: the load is driven to the dcache and has priority over draining. cpu_data_addr_ok = dcache_data_addr_ok.
  - Match, FWD_EN=1, youngest matching entry has wstrb==4'hF, state!=WAIT_LD: cpu_data_addr_ok=1 with no dcache request. rdata = that entry's wdata, with data_ok pulsed 1 cycle later (registered).
  - Any other match: cpu_data_addr_ok=0 (stall). The FIFO keeps draining until no matching entry remains.
  - Load in WAIT_ST or WAIT_LD with no forward: stall.
- Ordering:
  - CPU responses return in acceptance order.
  - No request is accepted while WAIT_LD is pending.
  - A store accepted at t has data_ok at t+1; a request accepted at t+1 has data_ok no earlier than t+2.
- Pointers wrap modulo DEPTH.
- sb_empty = (sb_count==0).
- sb_count and sb_empty are registered and update on the edge after a push or pop.

Test Plan:
- Stores to 0x100,0x104,0x108,0x10C (wstrb F) back to back, dcache addr_ok/data_ok delay 3 -> 4 addr_oks in 4 cycles, 4 data_oks each 1 cycle after its addr_ok, sb_count peaks at 4, dcache writes appear in order, sb_empty=1 after the final drain.
- Fifth store while full -> addr_ok=0 until the first pop; accepted the cycle after sb_count drops to 3.
- Store 0x200=0xDEADBEEF (F), then load 0x202 with FWD_EN=1 -> no dcache read, rdata=0xDEADBEEF one cycle after addr_ok.
- Store 0x300 wstrb 4'b0011, then load 0x300 -> load stalls until that entry's dcache data_ok; the load then goes to the dcache and returns dcache rdata.
- FIFO holds a store to 0x400; load 0x500 in IDLE -> load issued to the dcache before the drain, WAIT_LD, data_ok carries dcache rdata; the drain resumes afterwards.
- Assert resetn=0 during WAIT_ST with 3 entries -> sb_count=0, sb_empty=1, dcache_data_req=0 immediately; no data_ok after release.

Source files
------------

// File: rtl/store_buffer_fifo.sv
// rtl/store_buffer_fifo.sv - DEPTH-entry in-order store buffer between the CPU data port and the dcache
module store_buffer_fifo #(
    parameter int DEPTH  = 4,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cpu_data_req,
    input  logic             cpu_data_wr,
    input  logic [1:0]       cpu_data_size,
    input  logic [31:0]      cpu_data_addr,
    input  logic [31:0]      cpu_data_wdata,
    input  logic [3:0]       cpu_data_wstrb,
    output logic [31:0]      cpu_data_rdata,
    output logic             cpu_data_addr_ok,
    output logic             cpu_data_data_ok,
    output logic             dcache_data_req,
    output logic             dcache_data_wr,
    output logic [1:0]       dcache_data_size,
    output logic [31:0]      dcache_data_addr,
    output logic [31:0]      dcache_data_wdata,
    output logic [3:0]       dcache_data_wstrb,
    input  logic [31:0]      dcache_data_rdata,
    input  logic             dcache_data_addr_ok,
    input  logic             dcache_data_data_ok,
    output logic             sb_empty,
    output logic [CNT_W-1:0] sb_count
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_ST, WAIT_LD} state_t;

    state_t           state, state_next;
    logic [31:0]      ent_addr  [DEPTH];
    logic [1:0]       ent_size  [DEPTH];
    logic [31:0]      ent_wdata [DEPTH];
    logic [3:0]       ent_wstrb [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count, count_next;
    logic             empty_q;
    logic             resp_q;
    logic [31:0]      rdata_q;

    logic             hit;
    logic [PTR_W-1:0] young, idx;
    logic             st_req, ld_req, full;
    logic             st_accept, fwd, ld_issue;
    logic             pop, ld_done;
    logic             dc_req, dc_wr;
    logic [1:0]       dc_size;
    logic [31:0]      dc_addr, dc_wdata;
    logic [3:0]       dc_wstrb;

    // Walk oldest to youngest so the last match wins; the draining head entry is included.
    always_comb begin
        hit   = 1'b0;
        young = '0;
        idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (ent_valid[idx] && (ent_addr[idx][31:2] == cpu_data_addr[31:2])) begin
                hit   = 1'b1;
                young = idx;
            end
        end
    end

    assign st_req    = cpu_data_req & cpu_data_wr;
    assign ld_req    = cpu_data_req & ~cpu_data_wr;
    assign full      = (count == CNT_W'(DEPTH));
    assign st_accept = st_req && !full && (state != WAIT_LD);
    assign fwd       = ld_req && hit && FWD_EN && (ent_wstrb[young] == 4'hF) && (state != WAIT_LD);
    assign ld_issue  = ld_req && !hit && (state == IDLE);

    always_comb begin
        state_next = state;
        dc_req     = 1'b0;
        dc_wr      = 1'b0;
        dc_size    = 2'd0;
        dc_addr    = '0;
        dc_wdata   = '0;
        dc_wstrb   = '0;
        pop        = 1'b0;
        ld_done    = 1'b0;
        case (state)
            IDLE: begin
                if (ld_issue) begin
                    dc_req  = 1'b1;
                    dc_size = cpu_data_size;
                    dc_addr = cpu_data_addr;
                    if (dcache_data_addr_ok) state_next = WAIT_LD;
                end else if (ent_valid[head]) begin
                    dc_req   = 1'b1;
                    dc_wr    = 1'b1;
                    dc_size  = ent_size[head];
                    dc_addr  = ent_addr[head];
                    dc_wdata = ent_wdata[head];
                    dc_wstrb = ent_wstrb[head];
                    if (dcache_data_addr_ok) state_next = WAIT_ST;
                end
            end
            WAIT_ST: begin
                if (dcache_data_data_ok) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_LD: begin
                if (dcache_data_data_ok) begin
                    ld_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count;
        case ({st_accept, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            empty_q   <= 1'b1;
            ent_valid <= '0;
            resp_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            empty_q <= (count_next == '0);
            resp_q  <= st_accept | fwd;
            rdata_q <= fwd ? ent_wdata[young] : '0;
            if (st_accept) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PTR_W'(1);
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (st_accept) begin
            ent_addr[tail]  <= cpu_data_addr;
            ent_size[tail]  <= cpu_data_size;
            ent_wdata[tail] <= cpu_data_wdata;
            ent_wstrb[tail] <= cpu_data_wstrb;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign cpu_data_addr_ok  = resetn & (st_accept | fwd | (ld_issue & dcache_data_addr_ok));
    assign cpu_data_data_ok  = resetn & (resp_q | ld_done);
    assign cpu_data_rdata    = !resetn ? '0 : (ld_done ? dcache_data_rdata : rdata_q);
    assign dcache_data_req   = resetn & dc_req;
    assign dcache_data_wr    = resetn & dc_wr;
    assign dcache_data_size  = resetn ? dc_size : 2'd0;
    assign dcache_data_addr  = resetn ? dc_addr : '0;
    assign dcache_data_wdata = resetn ? dc_wdata : '0;
    assign dcache_data_wstrb = resetn ? dc_wstrb : '0;
    assign sb_count          = count;
    assign sb_empty          = empty_q;

endmodule

// File: tb/tb_store_buffer_fifo.sv
// tb/tb_store_buffer_fifo.sv - scoreboard bench for store_buffer_fifo with a fixed-latency dcache model
module tb_store_buffer_fifo;
    localparam int DLY   = 3;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             resetn;
    logic             cpu_data_req, cpu_data_wr;
    logic [1:0]       cpu_data_size;
    logic [31:0]      cpu_data_addr, cpu_data_wdata;
    logic [3:0]       cpu_data_wstrb;
    logic [31:0]      cpu_data_rdata;
    logic             cpu_data_addr_ok, cpu_data_data_ok;
    logic             dcache_data_req, dcache_data_wr;
    logic [1:0]       dcache_data_size;
    logic [31:0]      dcache_data_addr, dcache_data_wdata;
    logic [3:0]       dcache_data_wstrb;
    logic [31:0]      dc_rdata;
    logic             dc_addr_ok, dc_data_ok;
    logic             sb_empty;
    logic [CNT_W-1:0] sb_count;

    store_buffer_fifo #(.DEPTH(4), .FWD_EN(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr), .cpu_data_size(cpu_data_size),
        .cpu_data_addr(cpu_data_addr), .cpu_data_wdata(cpu_data_wdata), .cpu_data_wstrb(cpu_data_wstrb),
        .cpu_data_rdata(cpu_data_rdata), .cpu_data_addr_ok(cpu_data_addr_ok), .cpu_data_data_ok(cpu_data_data_ok),
        .dcache_data_req(dcache_data_req), .dcache_data_wr(dcache_data_wr), .dcache_data_size(dcache_data_size),
        .dcache_data_addr(dcache_data_addr), .dcache_data_wdata(dcache_data_wdata), .dcache_data_wstrb(dcache_data_wstrb),
        .dcache_data_rdata(dc_rdata), .dcache_data_addr_ok(dc_addr_ok), .dcache_data_data_ok(dc_data_ok),
        .sb_empty(sb_empty), .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // kind 0 = store, 1 = forwarded load, 2 = dcache load
    logic [1:0]  q_kind [$];
    logic [31:0] q_rdata[$];
    int          q_cyc  [$];
    logic        q_dwr  [$];
    logic [31:0] q_daddr[$];
    logic [31:0] q_dwdat[$];
    logic [3:0]  q_dstrb[$];

    task automatic exp_dc(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        q_dwr.push_back(wr);
        q_daddr.push_back(addr);
        q_dwdat.push_back(wdata);
        q_dstrb.push_back(strb);
    endtask

    // dcache: addr_ok after DLY+1 cycles of request, data_ok DLY+1 cycles later; reads return addr+0x1000_0000
    int          a_cnt = 0, d_cnt = 0;
    bit          busy = 1'b0;
    logic [31:0] pend_rdata;
    initial begin
        dc_addr_ok = 1'b0;
        dc_data_ok = 1'b0;
        dc_rdata   = '0;
    end

    always @(negedge clk) begin
        dc_addr_ok = 1'b0;
        dc_data_ok = 1'b0;
        if (!resetn) begin
            a_cnt = 0; d_cnt = 0; busy = 1'b0;
        end else if (busy) begin
            if (d_cnt == DLY) begin
                dc_data_ok = 1'b1; dc_rdata = pend_rdata; busy = 1'b0; d_cnt = 0;
            end else d_cnt++;
        end else if (dcache_data_req) begin
            if (a_cnt == DLY) begin
                dc_addr_ok = 1'b1; a_cnt = 0; busy = 1'b1;
                pend_rdata = dcache_data_addr + 32'h1000_0000;
                if (q_dwr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL dc_unexpected_txn actual=addr %h required=none", dcache_data_addr);
                end else begin
                    chk("dc_wr", dcache_data_wr, q_dwr.pop_front());
                    chk("dc_addr", dcache_data_addr, q_daddr.pop_front());
                    chk("dc_wdata", dcache_data_wdata, q_dwdat.pop_front());
                    chk("dc_wstrb", dcache_data_wstrb, q_dstrb.pop_front());
                    chk("dc_size", dcache_data_size, 2'd2);
                end
            end else a_cnt++;
        end else a_cnt = 0;
    end

    // CPU response monitor
    always @(negedge clk) begin
        #1;
        if (resetn && cpu_data_data_ok) begin
            if (q_kind.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_data_ok actual=1 required=0 cyc=%0d", cyc);
            end else begin
                logic [1:0]  k;
                logic [31:0] r;
                int          c;
                k = q_kind.pop_front();
                r = q_rdata.pop_front();
                c = q_cyc.pop_front();
                if (k != 2'd2) chk("resp_latency", cyc, c + 1);
                if (k != 2'd0) chk("load_rdata", cpu_data_rdata, r);
            end
        end
    end

    task automatic cpu_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [1:0] kind, input logic [31:0] exp_rdata,
                          output int waits, output int cnt_acc);
        int n;
        cpu_data_req = 1'b1; cpu_data_wr = wr; cpu_data_addr = addr;
        cpu_data_wdata = wdata; cpu_data_wstrb = strb;
        n = 0;
        forever begin
            @(negedge clk); #1;
            if (cpu_data_addr_ok) break;
            n++;
            if (n > 100) begin
                checks++; failures++;
                $display("FAIL accept_timeout actual=no addr_ok required=addr_ok addr=%h", addr);
                break;
            end
            @(posedge clk); #1;
        end
        waits = n;
        cnt_acc = int'(sb_count);
        if (n <= 100) begin
            q_kind.push_back(kind);
            q_rdata.push_back(exp_rdata);
            q_cyc.push_back(cyc);
        end
        @(posedge clk); #1;
        cpu_data_req = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (!sb_empty && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("sb_empty_after_drain", sb_empty, 1'b1);
        repeat (12) @(posedge clk);
        #1;
    endtask

    int w, ca;

    initial begin
        resetn = 1'b0;
        cpu_data_req = 1'b0; cpu_data_wr = 1'b0; cpu_data_size = 2'd2;
        cpu_data_addr = '0; cpu_data_wdata = '0; cpu_data_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sb_empty", sb_empty, 1'b1);
        chk("rst_sb_count", sb_count, 0);
        chk("rst_data_ok", cpu_data_data_ok, 1'b0);
        chk("rst_rdata", cpu_data_rdata, 32'h0);
        chk("rst_dc_req", dcache_data_req, 1'b0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Back-to-back stores, then a fifth while full
        for (int i = 0; i < 5; i++)
            exp_dc(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) begin
            cpu_op(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 2'd0, 32'h0, w, ca);
            chk("burst_no_stall", w, 0);
        end
        chk("count_peak", sb_count, 4);
        cpu_op(1'b1, 32'h110, 32'hA000_0004, 4'hF, 2'd0, 32'h0, w, ca);
        chk("full_stalled", (w > 0), 1'b1);
        chk("full_accept_count", ca, 3);
        wait_empty();

        // Full-word forward
        exp_dc(1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF);
        cpu_op(1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF, 2'd0, 32'h0, w, ca);
        cpu_op(1'b0, 32'h202, 32'h0, 4'h0, 2'd1, 32'hDEAD_BEEF, w, ca);
        chk("fwd_no_stall", w, 0);
        wait_empty();

        // Partial store hazard: load waits for the drain, then reads the dcache
        exp_dc(1'b1, 32'h300, 32'h0000_1234, 4'h3);
        exp_dc(1'b0, 32'h300, 32'h0, 4'h0);
        cpu_op(1'b1, 32'h300, 32'h0000_1234, 4'h3, 2'd0, 32'h0, w, ca);
        cpu_op(1'b0, 32'h300, 32'h0, 4'h0, 2'd2, 32'h1000_0300, w, ca);
        chk("partial_stalled", (w > 0), 1'b1);
        chk("partial_accept_count", ca, 0);
        wait_empty();

        // Non-hazard load bypasses a pending drain
        exp_dc(1'b0, 32'h500, 32'h0, 4'h0);
        exp_dc(1'b1, 32'h400, 32'h0000_0044, 4'hF);
        cpu_op(1'b1, 32'h400, 32'h0000_0044, 4'hF, 2'd0, 32'h0, w, ca);
        cpu_op(1'b0, 32'h500, 32'h0, 4'h0, 2'd2, 32'h1000_0500, w, ca);
        chk("bypass_accept_count", ca, 1);
        wait_empty();

        // Reset during WAIT_ST with three entries
        for (int i = 0; i < 3; i++) begin
            exp_dc(1'b1, 32'h600 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF);
            cpu_op(1'b1, 32'h600 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF, 2'd0, 32'h0, w, ca);
        end
        for (int n = 0; n < 50; n++) begin
            @(negedge clk); #1;
            if (dc_addr_ok) break;
        end
        @(posedge clk); #1;
        chk("pre_reset_count", sb_count, 3);
        resetn = 1'b0;
        #1;
        chk("mid_rst_count", sb_count, 0);
        chk("mid_rst_empty", sb_empty, 1'b1);
        chk("mid_rst_dc_req", dcache_data_req, 1'b0);
        chk("mid_rst_data_ok", cpu_data_data_ok, 1'b0);
        q_dwr.delete(); q_daddr.delete(); q_dwdat.delete(); q_dstrb.delete();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_dc_req", dcache_data_req, 1'b0);
        chk("resp_queue_drained", q_kind.size(), 0);
        chk("dc_queue_drained", q_dwr.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
